// File: rtl/shifter_pkg.sv
// Shared types for the rotate shifters: operand/shift-amount widths and the
// payload carried by each pipeline register.
package shifter_pkg;

    localparam int unsigned WIDTH   = 64;
    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned TAG_W   = 4;

    typedef logic [WIDTH-1:0]   data_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

    typedef struct packed {
        data_t              data;
        shamt_t             shamt;
        logic [TAG_W-1:0]   tag;
    } ror_pipe_t;

endpackage

// File: rtl/stage_if.sv
// Connection bundle for one conditional rotate stage: operand in, select, result out.
interface stage_if;
    import shifter_pkg::*;

    data_t in;
    data_t out;
    logic  sig;

    modport stage (input in, input sig, output out);
    modport host  (output in, output sig, input out);

endinterface

// File: rtl/stage_ror.sv
// One combinational barrel stage: rotates right by SHAMT when sig is set,
// otherwise passes the operand through.
module stage_ror
    import shifter_pkg::*;
#(
    parameter int unsigned SHAMT = 1
) (
    stage_if.stage s
);

    data_t rotated;

    assign rotated = {s.in[SHAMT-1:0], s.in[WIDTH-1:SHAMT]};
    assign s.out   = s.sig ? rotated : s.in;

endmodule

// File: rtl/ror_shifter_pipe.sv
// Pipelined 64-bit rotate-right: six binary stages, a register after every
// second stage, valid/ready on both ends with collapsing bubbles.
module ror_shifter_pipe
    import shifter_pkg::ror_pipe_t;
    import shifter_pkg::data_t;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero
);

    ror_pipe_t   p0, p1, p2;
    logic [2:0]  v;
    logic [2:0]  en;
    data_t [5:0] stage_in;
    data_t [5:0] stage_out;
    logic  [5:0] stage_sig;

    // A stage advances when it is empty or its successor advances, so a
    // bubble anywhere lets everything upstream of it move.
    assign en[2]    = !v[2] || out_ready;
    assign en[1]    = !v[1] || en[2];
    assign en[0]    = !v[0] || en[1];
    assign in_ready = en[0];

    assign stage_in[0] = in_data;
    assign stage_in[1] = stage_out[0];
    assign stage_in[2] = p0.data;
    assign stage_in[3] = stage_out[2];
    assign stage_in[4] = p1.data;
    assign stage_in[5] = stage_out[4];

    assign stage_sig = {p1.shamt[5:4], p0.shamt[3:2], in_shamt[1:0]};

    for (genvar k = 0; k < 6; k++) begin : g_stage
        stage_if sif ();

        assign sif.in       = stage_in[k];
        assign sif.sig      = stage_sig[k];
        assign stage_out[k] = sif.out;

        stage_ror #(.SHAMT(1 << k)) u_stage (.s(sif));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            if (en[0]) v[0] <= in_valid;
            if (en[1]) v[1] <= v[0];
            if (en[2]) v[2] <= v[1];
        end
    end

    // Payload is only written when real data arrives; it is don't-care while its valid bit is low.
    always_ff @(posedge clk) begin
        if (en[0] && in_valid) p0 <= '{data: stage_out[1], shamt: in_shamt, tag: in_tag};
        if (en[1] && v[0])     p1 <= '{data: stage_out[3], shamt: p0.shamt, tag: p0.tag};
        if (en[2] && v[1])     p2 <= '{data: stage_out[5], shamt: p1.shamt, tag: p1.tag};
    end

    assign out_valid = v[2];
    assign out_data  = p2.data;
    assign out_tag   = p2.tag;
    assign out_zero  = (p2.data == '0);

    // Shift-amount bits already consumed upstream travel along but are never read.
    logic unused_shamt_bits;
    assign unused_shamt_bits = ^{p0.shamt[1:0], p1.shamt[3:0], p2.shamt};

endmodule
